// File: rtl/conv_mac_array.sv
// Four-stage convolution MAC array: per-lane dot products over CPF channels are
// accumulated across a frame, then biased, scaled, rectified and saturated on eop.
module conv_mac_array #(
  parameter int CPF        = 8,
  parameter int KPF        = 8,
  parameter int DW         = 16,
  parameter int WW         = 16,
  parameter int BIAS_DW    = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int SHIFT      = 13,
  parameter int BIAS_SHIFT = 13,
  parameter int RELU       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_din_en,
  input  logic                    op_din_eop,
  input  logic [CPF*DW-1:0]       op_din,
  input  logic [KPF*CPF*WW-1:0]   op_weight,
  input  logic [KPF*BIAS_DW-1:0]  op_bias,
  output logic [KPF*DW-1:0]       op_dout,
  output logic                    op_dout_en,
  output logic                    sat_flag
);

  localparam int PW = DW + WW;
  // Two guard bits keep acc + shifted bias exact before the output clamp.
  localparam int EW = ACC_WIDTH + 2;
  localparam logic signed [EW-1:0] OUT_MAX = (EW'(1) <<< (DW - 1)) - EW'(1);
  localparam logic signed [EW-1:0] OUT_MIN = ~OUT_MAX;

  // Datapath registers (no reset needed; validity is carried by the tags).
  logic signed [PW-1:0]        prod_d [KPF][CPF];
  logic signed [PW-1:0]        prod_q [KPF][CPF];
  logic signed [ACC_WIDTH-1:0] sum_d  [KPF];
  logic signed [ACC_WIDTH-1:0] sum_q  [KPF];
  logic [KPF*BIAS_DW-1:0]      bias1_q, bias2_q, bias3_q;

  // Control and state registers (cleared by reset).
  logic                        v1_q, eop1_q, v2_q, eop2_q, tag3_q;
  logic                        first_d, first_q;
  logic signed [ACC_WIDTH-1:0] acc_d [KPF];
  logic signed [ACC_WIDTH-1:0] acc_q [KPF];

  // Output stage.
  logic signed [EW-1:0]        wide_d [KPF];
  logic signed [EW-1:0]        shr_d  [KPF];
  logic signed [EW-1:0]        clip_d [KPF];
  logic [KPF*DW-1:0]           dout_d, dout_q;
  logic                        sat_hit_d;
  logic                        en_q, sat_q;

  // NOTE: every variable gets a value on every path through always_comb, so no latches form.
  always_comb begin
    for (int k = 0; k < KPF; k++) begin
      for (int c = 0; c < CPF; c++) begin
        prod_d[k][c] = PW'($signed(op_din[c*DW +: DW])) *
                       PW'($signed(op_weight[(k*CPF + c)*WW +: WW]));
      end
    end
  end

  always_comb begin
    for (int k = 0; k < KPF; k++) begin
      sum_d[k] = '0;
      for (int c = 0; c < CPF; c++) begin
        sum_d[k] = sum_d[k] + ACC_WIDTH'(prod_q[k][c]);
      end
    end
  end

  // The first beat of a frame overwrites the accumulator instead of adding to it.
  always_comb begin
    first_d = first_q;
    for (int k = 0; k < KPF; k++) begin
      acc_d[k] = acc_q[k];
    end
    if (v2_q) begin
      for (int k = 0; k < KPF; k++) begin
        acc_d[k] = (first_q ? '0 : acc_q[k]) + sum_q[k];
      end
      first_d = eop2_q;
    end
  end

  always_comb begin
    sat_hit_d = 1'b0;
    dout_d    = '0;
    for (int k = 0; k < KPF; k++) begin
      wide_d[k] = EW'(acc_q[k]) +
                  (EW'($signed(bias3_q[k*BIAS_DW +: BIAS_DW])) <<< BIAS_SHIFT);
      shr_d[k]  = wide_d[k] >>> SHIFT;
      clip_d[k] = shr_d[k];
      if ((RELU != 0) && shr_d[k][EW-1]) begin
        clip_d[k] = '0;
      end
      if (clip_d[k] > OUT_MAX) begin
        clip_d[k] = OUT_MAX;
        sat_hit_d = 1'b1;
      end else if (clip_d[k] < OUT_MIN) begin
        clip_d[k] = OUT_MIN;
        sat_hit_d = 1'b1;
      end
      dout_d[k*DW +: DW] = clip_d[k][DW-1:0];
    end
  end

  // NOTE: pure datapath pipes carry no reset; only state that decides behaviour is cleared.
  always_ff @(posedge clk) begin
    prod_q  <= prod_d;
    sum_q   <= sum_d;
    bias1_q <= op_bias;
    bias2_q <= bias1_q;
    bias3_q <= bias2_q;
  end

  // NOTE: non-blocking assignments keep every stage reading the pre-edge value of the previous one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      eop1_q  <= 1'b0;
      v2_q    <= 1'b0;
      eop2_q  <= 1'b0;
      tag3_q  <= 1'b0;
      first_q <= 1'b1;
      for (int k = 0; k < KPF; k++) begin
        acc_q[k] <= '0;
      end
      dout_q  <= '0;
      en_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      v1_q    <= op_din_en;
      eop1_q  <= op_din_en & op_din_eop;
      v2_q    <= v1_q;
      eop2_q  <= eop1_q;
      tag3_q  <= v2_q & eop2_q;
      first_q <= first_d;
      for (int k = 0; k < KPF; k++) begin
        acc_q[k] <= acc_d[k];
      end
      if (tag3_q) begin
        dout_q <= dout_d;
      end
      en_q    <= tag3_q;
      sat_q   <= sat_q | (tag3_q & sat_hit_d);
    end
  end

  assign op_dout    = dout_q;
  assign op_dout_en = en_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_conv_mac_array.sv
// Bench for conv_mac_array: table-driven directed frames, reset/back-to-back
// sequences, then random frames against an arithmetic reference model.
module tb_conv_mac_array;

  localparam int CPF = 8, KPF = 8, DW = 16, WW = 16, BIAS_DW = 16;
  localparam int ACC_WIDTH = 40, SHIFT = 13, BIAS_SHIFT = 13;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   op_din_en, op_din_eop;
  logic [CPF*DW-1:0]      op_din;
  logic [KPF*CPF*WW-1:0]  op_weight;
  logic [KPF*BIAS_DW-1:0] op_bias;
  logic [KPF*DW-1:0]      dout_r, dout_l;
  logic                   en_r, en_l, sat_r, sat_l;

  conv_mac_array #(.RELU(1)) dut (
    .clk(clk), .rst(rst), .op_din_en(op_din_en), .op_din_eop(op_din_eop),
    .op_din(op_din), .op_weight(op_weight), .op_bias(op_bias),
    .op_dout(dout_r), .op_dout_en(en_r), .sat_flag(sat_r));

  conv_mac_array #(.RELU(0)) dut_lin (
    .clk(clk), .rst(rst), .op_din_en(op_din_en), .op_din_eop(op_din_eop),
    .op_din(op_din), .op_weight(op_weight), .op_bias(op_bias),
    .op_dout(dout_l), .op_dout_en(en_l), .sat_flag(sat_l));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint lane(input logic [KPF*DW-1:0] v, input int k);
    return longint'($signed(v[k*DW +: DW]));
  endfunction

  // Current beat contents, packed onto the ports by drive().
  int dv [CPF];
  int wv [KPF][CPF];
  int bv [KPF];

  task automatic drive(input bit e, input bit p);
    op_din_en  = e;
    op_din_eop = p;
    for (int c = 0; c < CPF; c++) op_din[c*DW +: DW] = dv[c][DW-1:0];
    for (int k = 0; k < KPF; k++) begin
      op_bias[k*BIAS_DW +: BIAS_DW] = bv[k][BIAS_DW-1:0];
      for (int c = 0; c < CPF; c++) op_weight[(k*CPF + c)*WW +: WW] = wv[k][c][WW-1:0];
    end
  endtask

  task automatic load_uniform(input int d, input int w, input int b);
    for (int c = 0; c < CPF; c++) dv[c] = d;
    for (int k = 0; k < KPF; k++) begin
      bv[k] = b;
      for (int c = 0; c < CPF; c++) wv[k][c] = w;
    end
  endtask

  // Called at a negedge; returns cycles from c0 to the first op_dout_en seen, or -1.
  task automatic wait_pulse(input int c0, output int lat);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (en_r) begin
        lat = cyc - c0;
        break;
      end
    end
  endtask

  typedef struct {
    int din; int wt; int bias; int nbeats; int gap;
    int exp_r; int exp_l; bit sat_r; bit sat_l;
  } vec_t;
  vec_t vecs [8];

  task automatic run_vec(input vec_t v, input int idx);
    int c0, lat;
    load_uniform(v.din, v.wt, v.bias);
    @(negedge clk); drive(1'b1, v.nbeats == 1); c0 = cyc;
    if (v.nbeats > 1) begin
      for (int g = 0; g < v.gap; g++) begin
        @(negedge clk); drive(1'b0, 1'b1);      // eop without en must be ignored
      end
      for (int b = 2; b <= v.nbeats; b++) begin
        @(negedge clk); drive(1'b1, b == v.nbeats); c0 = cyc;
      end
    end
    @(negedge clk); drive(1'b0, 1'b0);
    wait_pulse(c0, lat);
    check($sformatf("vec%0d_latency", idx), lat, 4);
    if (lat >= 0) begin
      check($sformatf("vec%0d_en_lin", idx), en_l, 1);
      for (int k = 0; k < KPF; k++) begin
        check($sformatf("vec%0d_relu_lane%0d", idx, k), lane(dout_r, k), v.exp_r);
        check($sformatf("vec%0d_lin_lane%0d", idx, k), lane(dout_l, k), v.exp_l);
      end
    end
    check($sformatf("vec%0d_sat_relu", idx), sat_r, v.sat_r);
    check($sformatf("vec%0d_sat_lin", idx), sat_l, v.sat_l);
    @(negedge clk);
    check($sformatf("vec%0d_single_pulse", idx), en_r, 0);
    check($sformatf("vec%0d_hold", idx), lane(dout_r, KPF-1), v.exp_r);
  endtask

  // Reference model: frames accumulate plain dot products; results derived on eop.
  typedef struct { int cyc; logic [KPF*DW-1:0] r; logic [KPF*DW-1:0] l; bit sr; bit sl; } exp_t;
  exp_t   exp_q [$];
  longint macc [KPF];
  bit     mfirst;
  bit     mon_on = 1'b0;
  bit     msat_r, msat_l;

  function automatic longint wrap_acc(input longint x);
    return (x <<< (64 - ACC_WIDTH)) >>> (64 - ACC_WIDTH);
  endfunction

  task automatic model_beat(input bit eop);
    exp_t e;
    longint s, t, hi, lo;
    hi = 64'sd32767;
    lo = -64'sd32768;
    for (int k = 0; k < KPF; k++) begin
      s = 0;
      for (int c = 0; c < CPF; c++) s += longint'(dv[c]) * longint'(wv[k][c]);
      macc[k] = wrap_acc(mfirst ? s : macc[k] + s);
    end
    mfirst = eop;
    if (eop) begin
      e.cyc = cyc + 4; e.sr = 1'b0; e.sl = 1'b0; e.r = '0; e.l = '0;
      for (int k = 0; k < KPF; k++) begin
        t = (macc[k] + (longint'(bv[k]) * (64'sd1 <<< BIAS_SHIFT))) >>> SHIFT;
        if (t > hi) begin e.l[k*DW +: DW] = hi[DW-1:0]; e.sl = 1'b1; end
        else if (t < lo) begin e.l[k*DW +: DW] = lo[DW-1:0]; e.sl = 1'b1; end
        else e.l[k*DW +: DW] = t[DW-1:0];
        if (t < 0) t = 0;
        if (t > hi) begin e.r[k*DW +: DW] = hi[DW-1:0]; e.sr = 1'b1; end
        else e.r[k*DW +: DW] = t[DW-1:0];
      end
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      bit   due;
      exp_t e;
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("rand_en_relu", en_r, due);
      check("rand_en_lin", en_l, due);
      if (due) begin
        e = exp_q.pop_front();
        msat_r |= e.sr;
        msat_l |= e.sl;
        for (int k = 0; k < KPF; k++) begin
          check($sformatf("rand_relu_lane%0d", k), lane(dout_r, k), lane(e.r, k));
          check($sformatf("rand_lin_lane%0d", k), lane(dout_l, k), lane(e.l, k));
        end
      end
      check("rand_sat_relu", sat_r, msat_r);
      check("rand_sat_lin", sat_l, msat_l);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int c0, lat;
    bit is_eop, full;

    //          din     wt     bias nb gap  relu    lin   satR satL
    vecs[0] = '{64,     8192,  0,   1, 0,   512,    512,    0, 0};
    vecs[1] = '{64,     8192,  0,   3, 2,   1536,   1536,   0, 0};
    vecs[2] = '{64,    -8192,  0,   1, 0,   0,     -512,    0, 0};
    vecs[3] = '{64,     8192,  64,  2, 1,   1088,   1088,   0, 0};
    vecs[4] = '{-100,   8192, -3,   1, 0,   0,     -803,    0, 0};
    vecs[5] = '{-1,     1,     0,   1, 0,   0,     -1,      0, 0};
    vecs[6] = '{32767,  32767, 0,   1, 0,   32767,  32767,  1, 1};
    vecs[7] = '{-32768, 32767, 0,   1, 0,   0,     -32768,  1, 1};

    rst = 1'b0;
    load_uniform(0, 0, 0);
    drive(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_en", en_r, 0);
    check("reset_dout", lane(dout_r, 0), 0);
    check("reset_sat", sat_r, 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    check("sat_sticky_relu", sat_r, 1);

    // Frame interrupted by reset is discarded; next beat starts a fresh frame.
    load_uniform(64, 8192, 0);
    @(negedge clk); drive(1'b1, 1'b0);
    @(negedge clk); drive(1'b1, 1'b0);
    @(negedge clk); drive(1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("async_clear_dout", lane(dout_r, 0), 0);
    check("async_clear_sat", sat_r, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_no_pulse", en_r, 0);
    end
    rst = 1'b1;
    @(negedge clk); drive(1'b1, 1'b1); c0 = cyc;
    @(negedge clk); drive(1'b0, 1'b0);
    wait_pulse(c0, lat);
    check("post_reset_latency", lat, 4);
    for (int k = 0; k < KPF; k++) check($sformatf("post_reset_lane%0d", k), lane(dout_r, k), 512);
    check("post_reset_sat_lin", sat_l, 0);

    // Back-to-back single-beat frames; bias changed after the last eop must not leak.
    load_uniform(64, 8192, 64);
    @(negedge clk); drive(1'b1, 1'b1); c0 = cyc;
    @(negedge clk); drive(1'b1, 1'b1);
    @(negedge clk); drive(1'b1, 1'b1);
    for (int k = 0; k < KPF; k++) bv[k] = 32767;
    @(negedge clk); drive(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bit exp_en;
      if (i > 0) @(negedge clk);
      exp_en = (cyc - c0 >= 4) && (cyc - c0 <= 6);
      check($sformatf("b2b_en_c%0d", cyc - c0), en_r, exp_en);
      if (exp_en) begin
        check($sformatf("b2b_lane0_c%0d", cyc - c0), lane(dout_r, 0), 576);
        check($sformatf("b2b_lane%0d_c%0d", KPF-1, cyc - c0), lane(dout_l, KPF-1), 576);
      end
    end

    // Random frames against the model.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mfirst = 1'b1;
    msat_r = 1'b0;
    msat_l = 1'b0;
    mon_on = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      full = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < CPF; c++)
        dv[c] = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 1023)) - 512;
      for (int k = 0; k < KPF; k++) begin
        bv[k] = int'($urandom_range(0, 511)) - 256;
        for (int c = 0; c < CPF; c++)
          wv[k][c] = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 16383)) - 8192;
      end
      is_eop = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, is_eop);
      end else begin
        drive(1'b1, is_eop);
        model_beat(is_eop);
      end
    end
    @(negedge clk); drive(1'b0, 1'b0);
    repeat (8) @(negedge clk);
    check("rand_drain", exp_q.size(), 0);
    mon_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
